// File: rtl/alu_ctrl_stage.sv
// ALU-control stage between decode and execute.
// Registers the decoded ALU code and sequences multi-cycle mul/div ops.
module alu_ctrl_stage #(
  parameter int OP_W       = 4,
  parameter int CTRL_W     = 5,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_d,
  input  logic [OP_W-1:0]   aluop,
  input  logic [5:0]        funct,
  input  logic              stall_d,
  input  logic              flush_e,
  output logic [CTRL_W-1:0] alucontrol_e,
  output logic              valid_e,
  output logic              illegal_e,
  output logic              md_start,
  output logic              md_signed,
  output logic              md_is_div,
  output logic              md_done,
  output logic              md_abort,
  output logic              stall_req
);

  localparam logic [OP_W-1:0] R_TYPE_OP = OP_W'(0);
  localparam logic [OP_W-1:0] ANDI_OP   = OP_W'(1);
  localparam logic [OP_W-1:0] XORI_OP   = OP_W'(2);
  localparam logic [OP_W-1:0] LUI_OP    = OP_W'(3);
  localparam logic [OP_W-1:0] ORI_OP    = OP_W'(4);
  localparam logic [OP_W-1:0] ADDI_OP   = OP_W'(5);
  localparam logic [OP_W-1:0] ADDIU_OP  = OP_W'(6);
  localparam logic [OP_W-1:0] SLTI_OP   = OP_W'(7);
  localparam logic [OP_W-1:0] SLTIU_OP  = OP_W'(8);
  localparam logic [OP_W-1:0] MEM_OP    = OP_W'(9);

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [CTRL_W-1:0] AND_C   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OR_C    = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] XOR_C   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] NOR_C   = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ADD_C   = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ADDU_C  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] SUB_C   = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] SUBU_C  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] SLT_C   = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] SLTU_C  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] SLL_C   = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] SRL_C   = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] SRA_C   = CTRL_W'(13);
  localparam logic [CTRL_W-1:0] SLLV_C  = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] SRLV_C  = CTRL_W'(15);
  localparam logic [CTRL_W-1:0] SRAV_C  = CTRL_W'(16);
  localparam logic [CTRL_W-1:0] LUI_C   = CTRL_W'(17);
  localparam logic [CTRL_W-1:0] MFHI_C  = CTRL_W'(18);
  localparam logic [CTRL_W-1:0] MTHI_C  = CTRL_W'(19);
  localparam logic [CTRL_W-1:0] MFLO_C  = CTRL_W'(20);
  localparam logic [CTRL_W-1:0] MTLO_C  = CTRL_W'(21);
  localparam logic [CTRL_W-1:0] MULT_C  = CTRL_W'(22);
  localparam logic [CTRL_W-1:0] MULTU_C = CTRL_W'(23);
  localparam logic [CTRL_W-1:0] DIV_C   = CTRL_W'(24);
  localparam logic [CTRL_W-1:0] DIVU_C  = CTRL_W'(25);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               start_n, abort_n;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_ill;
  logic               dec_md, dec_div;
  logic               hold, md_load;

  // aluop/funct -> ALU control code, illegal on default arms
  always_comb begin
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    unique case (1'b1)
      (aluop == R_TYPE_OP): begin
        unique case (funct)
          F_AND:   dec_ctrl = AND_C;
          F_OR:    dec_ctrl = OR_C;
          F_XOR:   dec_ctrl = XOR_C;
          F_NOR:   dec_ctrl = NOR_C;
          F_SLL:   dec_ctrl = SLL_C;
          F_SRL:   dec_ctrl = SRL_C;
          F_SRA:   dec_ctrl = SRA_C;
          F_SLLV:  dec_ctrl = SLLV_C;
          F_SRLV:  dec_ctrl = SRLV_C;
          F_SRAV:  dec_ctrl = SRAV_C;
          F_MTHI:  dec_ctrl = MTHI_C;
          F_MTLO:  dec_ctrl = MTLO_C;
          F_MFHI:  dec_ctrl = MFHI_C;
          F_MFLO:  dec_ctrl = MFLO_C;
          F_ADD:   dec_ctrl = ADD_C;
          F_ADDU:  dec_ctrl = ADDU_C;
          F_SUB:   dec_ctrl = SUB_C;
          F_SUBU:  dec_ctrl = SUBU_C;
          F_SLT:   dec_ctrl = SLT_C;
          F_SLTU:  dec_ctrl = SLTU_C;
          F_MULT:  dec_ctrl = MULT_C;
          F_MULTU: dec_ctrl = MULTU_C;
          F_DIV:   dec_ctrl = DIV_C;
          F_DIVU:  dec_ctrl = DIVU_C;
          default: dec_ill  = 1'b1;
        endcase
      end
      (aluop == ANDI_OP):  dec_ctrl = AND_C;
      (aluop == XORI_OP):  dec_ctrl = XOR_C;
      (aluop == LUI_OP):   dec_ctrl = LUI_C;
      (aluop == ORI_OP):   dec_ctrl = OR_C;
      (aluop == ADDI_OP):  dec_ctrl = ADD_C;
      (aluop == ADDIU_OP): dec_ctrl = ADDU_C;
      (aluop == SLTI_OP):  dec_ctrl = SLT_C;
      (aluop == SLTIU_OP): dec_ctrl = SLTU_C;
      (aluop == MEM_OP):   dec_ctrl = ADD_C;
      default:             dec_ill  = 1'b1;
    endcase
  end

  assign dec_div = (dec_ctrl == DIV_C)
                 | (dec_ctrl == DIVU_C);
  assign dec_md  = dec_div
                 | (dec_ctrl == MULT_C)
                 | (dec_ctrl == MULTU_C);

  assign hold    = stall_d | stall_req;
  assign md_load = valid_d & dec_md
                 & ~flush_e & ~hold;

  // E-stage register: flush beats stall beats load
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alucontrol_e <= '0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else if (flush_e) begin
      alucontrol_e <= '0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else if (!hold) begin
      alucontrol_e <= dec_ctrl;
      valid_e      <= valid_d;
      illegal_e    <= valid_d & dec_ill;
    end
  end

  // mul/div sequencer next-state and pulse requests
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start_n = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (md_load) begin
          state_n = BUSY;
          start_n = 1'b1;
          cnt_n   = dec_div
                  ? CNT_W'(DIV_CYCLES - 1)
                  : CNT_W'(MUL_CYCLES - 1);
        end
      end
      BUSY: begin
        if (flush_e) begin
          state_n = IDLE;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (cnt != '0) begin
          cnt_n   = cnt - CNT_W'(1);
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sequencer state, counter and pulse registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      md_start <= 1'b0;
      md_abort <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      md_start <= start_n;
      md_abort <= abort_n;
    end
  end

  assign stall_req = (state == BUSY);
  assign md_done   = (state == DONE);
  assign md_signed = (alucontrol_e == MULT_C)
                   | (alucontrol_e == DIV_C);
  assign md_is_div = (alucontrol_e == DIV_C)
                   | (alucontrol_e == DIVU_C);

endmodule
